dog_extrema: RTL and testbench

Difference-of-Gaussians and 3×3 extremum detector for the SIFT pipeline. Sits directly downstream of two Gaussian blur stages running on the same pixel stream at adjacent scales. Each accepted pixel pair is subtracted into a signed DoG sample. A 3×3 DoG window is kept in two internal line buffers, and a keypoint is flagged, with its image coordinates, when the window centre is a strict local maximum or minimum beyond a threshold.

---
 rtl/dog_extrema.sv | 118 +++++++++++
 tb/tb_dog_extrema.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dog_extrema.sv
// Difference-of-Gaussians sample generator with a 3x3 strict-extremum keypoint detector.
// Two line buffers plus a shifting 3x3 window; keypoints emerge two cycles after the completing pixel.
module dog_extrema #(
  parameter int WIDTH  = 400,
  parameter int HEIGHT = 300,
  parameter int THRESH = 3,
  parameter int XW     = 9,
  parameter int YW     = 9
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clk_en,
  input  logic          sof,
  input  logic [7:0]    g_a,
  input  logic [7:0]    g_b,
  output logic [8:0]    dog,
  output logic          dog_valid,
  output logic          kp_valid,
  output logic          kp_is_max,
  output logic [XW-1:0] kp_x,
  output logic [YW-1:0] kp_y,
  output logic          frame_done
);

  localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);
  localparam logic signed [8:0] THR_P = 9'(THRESH);
  localparam logic signed [8:0] THR_N = 9'(-THRESH);

  logic [XW-1:0] x, px;
  logic [YW-1:0] y, py;
  logic signed [8:0] d, rd0, rd1;
  logic signed [8:0] lb0 [WIDTH];
  logic signed [8:0] lb1 [WIDTH];
  // win[row][col]: row 0 is two lines up, col 2 is the newest column
  logic signed [8:0] win [3][3];
  logic          s1_v;
  logic [XW-1:0] s1_x;
  logic [YW-1:0] s1_y;
  logic          gt_all, lt_all, is_max, is_min;

  assign px  = sof ? '0 : x;
  assign py  = sof ? '0 : y;
  assign d   = $signed({1'b0, g_a}) - $signed({1'b0, g_b});
  assign rd0 = lb0[px];
  assign rd1 = lb1[px];

  always_ff @(posedge clk) begin
    if (clk_en) begin
      lb1[px] <= rd0;
      lb0[px] <= d;
    end
  end

  always_comb begin
    gt_all = 1'b1;
    lt_all = 1'b1;
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 3; c++) begin
        if (!(r == 1 && c == 1)) begin
          if (!(win[1][1] > win[r][c])) gt_all = 1'b0;
          if (!(win[1][1] < win[r][c])) lt_all = 1'b0;
        end
      end
    end
    is_max = gt_all && (win[1][1] > THR_P);
    is_min = lt_all && (win[1][1] < THR_N);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x          <= '0;
      y          <= '0;
      dog        <= '0;
      dog_valid  <= 1'b0;
      frame_done <= 1'b0;
      s1_v       <= 1'b0;
      s1_x       <= '0;
      s1_y       <= '0;
      kp_valid   <= 1'b0;
      kp_is_max  <= 1'b0;
      kp_x       <= '0;
      kp_y       <= '0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++)
          win[r][c] <= '0;
    end else begin
      dog_valid  <= clk_en;
      frame_done <= clk_en && (px == X_LAST) && (py == Y_LAST);
      s1_v       <= clk_en && (px >= XW'(2)) && (py >= YW'(2));
      if (clk_en) begin
        dog  <= d;
        s1_x <= px - XW'(1);
        s1_y <= py - YW'(1);
        if (px == X_LAST) begin
          x <= '0;
          y <= (py == Y_LAST) ? '0 : py + YW'(1);
        end else begin
          x <= px + XW'(1);
          y <= py;
        end
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
        end
        win[0][2] <= rd1;
        win[1][2] <= rd0;
        win[2][2] <= d;
      end
      // compare stage runs on the edge after the window loads, stalled or not
      kp_valid  <= s1_v && (is_max || is_min);
      kp_is_max <= s1_v && is_max;
      kp_x      <= (s1_v && (is_max || is_min)) ? s1_x : '0;
      kp_y      <= (s1_v && (is_max || is_min)) ? s1_y : '0;
    end
  end

endmodule

// File: tb/tb_dog_extrema.sv
// Self-checking bench for dog_extrema on an 8x6 frame, with a whole-image extremum model.
module tb_dog_extrema;
  localparam int W  = 8;
  localparam int H  = 6;
  localparam int TH = 3;

  logic       clk = 1'b0, rst = 1'b0, clk_en = 1'b0, sof = 1'b0;
  logic [7:0] g_a = '0, g_b = '0;
  logic [8:0] dog;
  logic       dog_valid, kp_valid, kp_is_max, frame_done;
  logic [2:0] kp_x, kp_y;

  dog_extrema #(.WIDTH(W), .HEIGHT(H), .THRESH(TH), .XW(3), .YW(3)) dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sof(sof), .g_a(g_a), .g_b(g_b),
    .dog(dog), .dog_valid(dog_valid), .kp_valid(kp_valid), .kp_is_max(kp_is_max),
    .kp_x(kp_x), .kp_y(kp_y), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  int img_a [H][W];
  int img_b [H][W];
  bit pend_v = 0;
  int pend_x, pend_y, pend_max;
  int kp_cnt, fd_cnt, last_kx, last_ky, last_kmax, dog22;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int dv(input int x, input int y);
    return img_a[y][x] - img_b[y][x];
  endfunction

  // 0 = none, 1 = maximum, 2 = minimum, judged on the full image
  function automatic int ext(input int cx, input int cy);
    int c = dv(cx, cy);
    bit gt = 1, lt = 1;
    for (int dy = -1; dy <= 1; dy++)
      for (int dx = -1; dx <= 1; dx++)
        if (dx != 0 || dy != 0) begin
          if (!(c > dv(cx + dx, cy + dy))) gt = 0;
          if (!(c < dv(cx + dx, cy + dy))) lt = 0;
        end
    if (gt && c > TH) return 1;
    if (lt && c < -TH) return 2;
    return 0;
  endfunction

  task automatic clear_img(input int a, input int b);
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++) begin
        img_a[y][x] = a;
        img_b[y][x] = b;
      end
  endtask

  task automatic step(input bit en, input bit s, input int x, input int y);
    int e;
    clk_en = en;
    sof    = s;
    if (en) begin
      g_a = 8'(img_a[y][x]);
      g_b = 8'(img_b[y][x]);
    end else begin
      g_a = 8'($urandom);
      g_b = 8'($urandom);
    end
    @(posedge clk);
    #1;
    chk("dog_valid", dog_valid, en);
    if (en) chk("dog", dog, dv(x, y) & 511);
    if (en && x == 2 && y == 2) dog22 = dog;
    chk("kp_valid", kp_valid, pend_v);
    if (pend_v) begin
      chk("kp_x", kp_x, pend_x);
      chk("kp_y", kp_y, pend_y);
      chk("kp_is_max", kp_is_max, pend_max);
    end
    if (kp_valid) begin
      kp_cnt++;
      last_kx = kp_x;
      last_ky = kp_y;
      last_kmax = kp_is_max;
    end
    chk("frame_done", frame_done, en && x == W - 1 && y == H - 1);
    if (frame_done) fd_cnt++;
    pend_v = 0;
    if (en && x >= 2 && y >= 2) begin
      e = ext(x - 1, y - 1);
      if (e != 0) begin
        pend_v = 1;
        pend_x = x - 1;
        pend_y = y - 1;
        pend_max = (e == 1);
      end
    end
  endtask

  task automatic run_frame(input bit gaps, input int npix);
    for (int i = 0; i < npix; i++) begin
      if (gaps && $urandom_range(0, 1) == 1)
        repeat ($urandom_range(1, 5)) step(0, 0, i % W, i / W);
      step(1, i == 0, i % W, i / W);
    end
  endtask

  task automatic frame_test(input string name, input bit gaps, input int exp_kps);
    kp_cnt = 0;
    fd_cnt = 0;
    run_frame(gaps, W * H);
    repeat (3) step(0, 0, 0, 0);
    chk({name, "_kps"}, kp_cnt, exp_kps);
    chk({name, "_frame_done"}, fd_cnt, 1);
  endtask

  task automatic chk_zero(input string name);
    chk({name, "_dog"}, dog, 0);
    chk({name, "_dog_valid"}, dog_valid, 0);
    chk({name, "_kp_valid"}, kp_valid, 0);
    chk({name, "_kp_is_max"}, kp_is_max, 0);
    chk({name, "_kp_x"}, kp_x, 0);
    chk({name, "_kp_y"}, kp_y, 0);
    chk({name, "_frame_done"}, frame_done, 0);
  endtask

  initial begin
    int exp_n;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    clear_img(100, 100);
    frame_test("flat", 0, 0);

    clear_img(100, 100);
    img_a[3][4] = 110;
    frame_test("pos", 0, 1);
    chk("pos_x", last_kx, 4);
    chk("pos_y", last_ky, 3);
    chk("pos_max", last_kmax, 1);

    clear_img(100, 100);
    img_b[2][2] = 120;
    frame_test("neg", 0, 1);
    chk("neg_x", last_kx, 2);
    chk("neg_y", last_ky, 2);
    chk("neg_max", last_kmax, 0);
    chk("neg_dog", dog22, 9'h1EC);

    clear_img(100, 100);
    img_a[3][4] = 103;
    frame_test("thr3", 0, 0);
    img_a[3][4] = 104;
    frame_test("thr4", 0, 1);
    clear_img(100, 100);
    img_a[3][3] = 110;
    img_a[3][4] = 110;
    frame_test("tie", 0, 0);

    clear_img(100, 100);
    img_a[0][0] = 110;
    img_a[2][7] = 110;
    img_a[5][3] = 110;
    frame_test("border", 0, 0);

    clear_img(100, 100);
    img_a[3][4] = 110;
    frame_test("stall", 1, 1);
    chk("stall_x", last_kx, 4);
    chk("stall_y", last_ky, 3);
    chk("stall_max", last_kmax, 1);

    // aborted frame ends on the pixel completing the spike window; its keypoint must still emit
    kp_cnt = 0;
    fd_cnt = 0;
    run_frame(0, 38);
    run_frame(0, W * H);
    repeat (3) step(0, 0, 0, 0);
    chk("abort_kps", kp_cnt, 2);
    chk("abort_frame_done", fd_cnt, 1);

    for (int f = 0; f < 4; f++) begin
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++) begin
          img_a[y][x] = $urandom_range(92, 108);
          img_b[y][x] = $urandom_range(95, 105);
        end
      exp_n = 0;
      for (int y = 1; y < H - 1; y++)
        for (int x = 1; x < W - 1; x++)
          if (ext(x, y) != 0) exp_n++;
      frame_test("rand", f[0], exp_n);
    end

    clear_img(100, 100);
    img_a[3][4] = 110;
    run_frame(0, 38);
    #2;
    rst = 1'b0;
    #1;
    chk_zero("midreset");
    pend_v = 0;
    clk_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("midreset_hold_kp", kp_valid, 0);
    #2;
    rst = 1'b1;
    frame_test("after_reset", 0, 1);
    chk("after_reset_x", last_kx, 4);
    chk("after_reset_y", last_ky, 3);
    chk("after_reset_max", last_kmax, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
